cursor_input_ctrl: RTL
======================

# cursor_input_ctrl

Upstream input stage for the tic-tac-toe game logic. It synchronises and debounces the raw active-low `move` and `select` keys and keeps a board cursor (cells 0..8) that skips occupied cells. On a confirmed selection it issues a one-cycle play strobe carrying the chosen cell. Its `cursor` output drives the game's position inputs and the video controller's highlight selector, replacing the free-running counter/selector pair.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a key level change (20 ms at 50 MHz).
- `CNT_W`, default 20: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- `CLOCK_50`  in  1: sole clock; all logic on its rising edge.
- `reset`  in  1: synchronous, active-high; clears all state on the next edge.
- `move_n`  in  1: raw move key, asynchronous, active-low.
- `select_n`  in  1: raw select key, asynchronous, active-low.
- `occupied`  in  9: bit i = 1 when cell i is taken (bit 0 = top-left, row-major).
- `game_over`  in  1: level from game logic; nonzero winner or draw.
- `cursor`  out  4: highlighted cell 0..8; 4'hF = none (locked).
- `play_x`  out  1: one-cycle strobe requesting a player move at `play_cell`.
- `play_cell`  out  4: cell for `play_x`; held until the next strobe.
- `locked`  out  1: 1 while in LOCKED.

## Operation
- Each key passes through a 2-flop synchroniser, then a debouncer. The debounced level starts at 1 (released). It flips only after the synchronised input has differed from it for `DEBOUNCE_CYCLES` consecutive cycles. Any agreeing sample clears the counter.
- Press pulse: a one-cycle pulse on the debounced 1→0 transition. Release generates nothing.
- FSM states: SEEK, READY, COMMIT, WAIT, LOCKED. A 4-bit scan index `idx` and a 4-bit scan count `n` support SEEK.
- Reset: state SEEK, idx=0, n=0, cursor=0, play_x=0, play_cell=0, locked=0, debounced levels=1, debounce counters=0.
- SEEK: examine one cell per cycle.
  - If `occupied[idx]`=0, load cursor=idx and go to READY.
  - Otherwise set idx = (idx==8) ? 0 : idx+1 and n=n+1.
  - After 9 examinations with no free cell, go to LOCKED.
  - cursor holds its previous value throughout SEEK.
- READY:
  - select pulse → COMMIT.
  - Otherwise move pulse → SEEK with idx = cursor+1 (wrapping 8→0) and n=0.
  - Otherwise `occupied[cursor]` rising externally → SEEK with idx=cursor and n=0.
- COMMIT (1 cycle): play_x=1, play_cell=cursor; then go to WAIT.
- WAIT: when `occupied[play_cell]`=1, go to SEEK with idx = play_cell+1 (wrapping) and n=0. Key pulses are ignored.
- LOCKED: cursor=4'hF, locked=1, play_x=0. Exit only via reset.
- `game_over`=1 in any state moves the FSM to LOCKED on the next edge. This has priority over every other transition.
- A simultaneous move and select pulse in READY is treated as select; the move is dropped.
- Pulses arriving outside READY are discarded, not queued.
- Single free cell: a move press rescans 9 cells and lands back on the same cursor.

## Timing
- Key press to pulse: 2 synchroniser cycles + `DEBOUNCE_CYCLES`, ±1 cycle.
- Move pulse at cycle t:
  - SEEK occupies t+1 .. t+k, where k is the number of cells examined (1..9).
  - cursor updates at t+k+1 when a free cell is found.
- Select pulse at cycle t: COMMIT at t+1, so play_x=1 during cycle t+1 only.
- game_over asserted in cycle t: locked=1 and cursor=4'hF from t+1.
- Reset mid-operation (any state, including COMMIT): all outputs return to reset values on the next edge, and play_x is never extended.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
Bench uses DEBOUNCE_CYCLES=4.
- Bounce: toggle move_n every 2 cycles for 20 cycles, then hold 0 → exactly one move pulse; cursor 0→1 on an empty board.
- Skip and wrap: occupied=9'b1_1000_0110, cursor=0, one move → cursor=3. Move ×2 more → 4, then 5. Starting from cursor=5, a move lands on 6.
- Commit: cursor=4, select press → one play_x pulse with play_cell=4. Set occupied[4]=1 three cycles later → cursor=5 two cycles after that.
- Simultaneous: drive move_n and select_n low together → one play_x pulse, and cursor unchanged until WAIT completes.
- Full board / game over: occupied=9'h1FF → locked=1, cursor=4'hF. Separately, game_over=1 during WAIT → locked the next cycle, and further presses produce no play_x.
- Reset during COMMIT → play_x=0, cursor=0, state SEEK; the first free cell is reloaded within 10 cycles.

Source files
------------

// File: rtl/cursor_input_ctrl_if.sv
// ---------------------------------------------------------------------------
// cursor_input_ctrl_if
// Bundles the key inputs, board status and play/cursor outputs that pass
// between the cursor input stage and its surroundings (keys + game logic).
//   move_n, select_n : raw active-low keys (asynchronous)
//   occupied[8:0]    : cell taken flags, bit 0 = top-left, row-major
//   game_over        : game finished (winner or draw)
//   cursor[3:0]      : highlighted cell 0..8, 4'hF when locked
//   play_x           : one-cycle move request at play_cell
//   play_cell[3:0]   : cell of the last move request
//   locked           : input stage locked until reset
// master = environment side, slave = cursor_input_ctrl.
// ---------------------------------------------------------------------------
interface cursor_input_ctrl_if;
  logic       move_n;
  logic       select_n;
  logic [8:0] occupied;
  logic       game_over;
  logic [3:0] cursor;
  logic       play_x;
  logic [3:0] play_cell;
  logic       locked;

  modport master (
    output move_n, select_n, occupied, game_over,
    input  cursor, play_x, play_cell, locked
  );

  modport slave (
    input  move_n, select_n, occupied, game_over,
    output cursor, play_x, play_cell, locked
  );
endinterface

// File: rtl/cursor_input_ctrl.sv
// ---------------------------------------------------------------------------
// cursor_input_ctrl
// Input stage for the tic-tac-toe game: synchronises and debounces the
// move/select keys, keeps a cursor on a free board cell (skipping taken
// cells) and issues a one-cycle play strobe on a confirmed selection.
// Ports:
//   CLOCK_50 : sole clock, rising edge
//   reset    : synchronous, active-high
//   bus      : cursor_input_ctrl_if.slave (keys, board status, outputs)
// Parameters:
//   DEBOUNCE_CYCLES : stable cycles needed to accept a key level change
//   CNT_W           : debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
// ---------------------------------------------------------------------------
module cursor_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  cursor_input_ctrl_if.slave    bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int KEY_MOVE   = 0;
  localparam int KEY_SELECT = 1;

  typedef enum logic [2:0] {
    S_SEEK,
    S_READY,
    S_COMMIT,
    S_WAIT,
    S_LOCKED
  } state_e;

  // -------------------------------------------------------------------------
  // Key conditioning: 2-flop synchroniser + debouncer + press detector.
  // Index 0 = move, index 1 = select.
  // -------------------------------------------------------------------------
  logic [1:0]       raw_keys;
  logic [1:0]       sync0_q;
  logic [1:0]       sync1_q;
  logic [1:0]       deb_q;
  logic [1:0]       press_q;
  logic [CNT_W-1:0] cnt_q [2];

  assign raw_keys = {bus.select_n, bus.move_n};

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      // Synchroniser starts at the released level so leaving reset cannot
      // look like a key press.
      sync0_q <= '1;
      sync1_q <= '1;
      deb_q   <= '1;
      press_q <= '0;
      for (int k = 0; k < 2; k++) cnt_q[k] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of the others, whatever the statement order.
      sync0_q <= raw_keys;
      sync1_q <= sync0_q;
      for (int k = 0; k < 2; k++) begin
        press_q[k] <= 1'b0;
        if (sync1_q[k] == deb_q[k]) begin
          cnt_q[k] <= '0;
        end else if (cnt_q[k] == CNT_LAST) begin
          // The DEBOUNCE_CYCLES-th consecutive differing sample: accept it.
          deb_q[k]   <= sync1_q[k];
          cnt_q[k]   <= '0;
          press_q[k] <= ~sync1_q[k];  // only the 1->0 edge is a press
        end else begin
          cnt_q[k] <= cnt_q[k] + 1'b1;
        end
      end
    end
  end

  logic move_p;
  logic sel_p;
  assign move_p = press_q[KEY_MOVE];
  assign sel_p  = press_q[KEY_SELECT];

  // -------------------------------------------------------------------------
  // Cursor FSM with registered outputs.
  // -------------------------------------------------------------------------
  state_e     state_q;
  logic [3:0] idx_q;
  logic [3:0] n_q;
  logic [3:0] cursor_q;
  logic       play_x_q;
  logic [3:0] play_cell_q;
  logic       locked_q;

  function automatic logic [3:0] next_cell(input logic [3:0] c);
    return (c == 4'd8) ? 4'd0 : c + 4'd1;
  endfunction

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= S_SEEK;
      idx_q       <= 4'd0;
      n_q         <= 4'd0;
      cursor_q    <= 4'd0;
      play_x_q    <= 1'b0;
      play_cell_q <= 4'd0;
      locked_q    <= 1'b0;
    end else if (bus.game_over) begin
      // Game end overrides every other transition.
      state_q  <= S_LOCKED;
      cursor_q <= 4'hF;
      locked_q <= 1'b1;
      play_x_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_SEEK: begin
          // One cell per cycle; cursor keeps its old value until a hit.
          if (!bus.occupied[idx_q]) begin
            cursor_q <= idx_q;
            state_q  <= S_READY;
          end else if (n_q == 4'd8) begin
            // Ninth taken cell in a row: the board is full.
            state_q  <= S_LOCKED;
            cursor_q <= 4'hF;
            locked_q <= 1'b1;
          end else begin
            idx_q <= next_cell(idx_q);
            n_q   <= n_q + 4'd1;
          end
        end

        S_READY: begin
          // Select wins over a coincident move; the move is dropped.
          if (sel_p) begin
            state_q     <= S_COMMIT;
            play_x_q    <= 1'b1;
            play_cell_q <= cursor_q;
          end else if (move_p) begin
            state_q <= S_SEEK;
            idx_q   <= next_cell(cursor_q);
            n_q     <= 4'd0;
          end else if (bus.occupied[cursor_q]) begin
            // The cursor cell was free on entry, so a set bit here means it
            // was just taken from outside: rescan starting at it.
            state_q <= S_SEEK;
            idx_q   <= cursor_q;
            n_q     <= 4'd0;
          end
        end

        S_COMMIT: begin
          play_x_q <= 1'b0;
          state_q  <= S_WAIT;
        end

        S_WAIT: begin
          // Hold until the game logic has recorded the move.
          if (bus.occupied[play_cell_q]) begin
            state_q <= S_SEEK;
            idx_q   <= next_cell(play_cell_q);
            n_q     <= 4'd0;
          end
        end

        S_LOCKED: begin
          cursor_q <= 4'hF;
          locked_q <= 1'b1;
          play_x_q <= 1'b0;
        end

        default: begin
          state_q  <= S_LOCKED;
          cursor_q <= 4'hF;
          locked_q <= 1'b1;
          play_x_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cursor    = cursor_q;
  assign bus.play_x    = play_x_q;
  assign bus.play_cell = play_cell_q;
  assign bus.locked    = locked_q;

endmodule
